// File: rtl/canvas_streamer.sv
// canvas_streamer
//   Streams a HEIGHT x WIDTH canvas of DATA_W-bit pixels in row-major order
//   over a valid/ready handshake, one pixel per transfer. It is started with a
//   one-cycle Start in IDLE and signals the end of a stream with a one-cycle
//   Done pulse. Abort cancels a running stream without producing Done.
//
// Optional feature macro: CANVAS_SNAPSHOT_EN
//   defined   - the whole canvas is copied into an internal buffer on the
//               Start edge, and every streamed pixel comes from that copy.
//   undefined - there is no buffer. Each pixel is read live from canvas on
//               the edge that loads it into the output register.
//
// Ports
//   Clk          system clock
//   Reset        synchronous, active-high; has priority over Start and Abort
//   Start        one-cycle request to stream one canvas; honoured only in IDLE
//   Abort        cancels an in-progress stream (no Done)
//   canvas       pixel array, indexed canvas[y][x]
//   Pixel_data   current pixel value (registered)
//   Pixel_index  linear index y*WIDTH+x of Pixel_data (registered)
//   Pixel_valid  Pixel_data/Pixel_index/Pixel_last are valid (registered)
//   Pixel_last   high with the final pixel (registered)
//   Pixel_ready  consumer accepts the current pixel
//   Busy         stream in progress (registered)
//   Done         one-cycle pulse after the final transfer (registered)
module canvas_streamer #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  parameter int DATA_W = 16
) (
  input  logic                                        Clk,
  input  logic                                        Reset,
  input  logic                                        Start,
  input  logic                                        Abort,
  input  logic [HEIGHT-1:0][WIDTH-1:0][DATA_W-1:0]    canvas,
  output logic [DATA_W-1:0]                           Pixel_data,
  output logic [9:0]                                  Pixel_index,
  output logic                                        Pixel_valid,
  output logic                                        Pixel_last,
  input  logic                                        Pixel_ready,
  output logic                                        Busy,
  output logic                                        Done
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [9:0]    LAST_IDX = 10'(WIDTH * HEIGHT - 1);
  localparam logic [XW-1:0] X_MAX    = XW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d, x_nxt;
  logic [YW-1:0]     y_q, y_d, y_nxt;
  logic [DATA_W-1:0] data_q, data_d, pix_nxt;
  logic [9:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer;

`ifdef CANVAS_SNAPSHOT_EN
  logic [HEIGHT-1:0][WIDTH-1:0][DATA_W-1:0] snap_q, snap_d;
`endif

  // Coordinates of the pixel that follows the one currently presented.
  always_comb begin
    if (x_q == X_MAX) begin
      x_nxt = '0;
      y_nxt = y_q + 1'b1;
    end else begin
      x_nxt = x_q + 1'b1;
      y_nxt = y_q;
    end
  end

  // The first pixel is always taken from canvas directly: in snapshot mode
  // the buffer is only being written on that same edge.
`ifdef CANVAS_SNAPSHOT_EN
  assign pix_nxt = snap_q[y_nxt][x_nxt];
`else
  assign pix_nxt = canvas[y_nxt][x_nxt];
`endif

  assign xfer = valid_q && Pixel_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef CANVAS_SNAPSHOT_EN
    snap_d  = snap_q;
`endif
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
        if (Start) begin
          state_d = S_STREAM;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          data_d  = canvas[0][0];
          last_d  = (LAST_IDX == 10'd0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef CANVAS_SNAPSHOT_EN
          snap_d  = canvas;
`endif
        end
      end
      S_STREAM: begin
        // Abort wins even over the final transfer, so no Done is produced.
        if (Abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          last_d  = 1'b0;
        end else if (xfer) begin
          if (last_q) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d    = x_nxt;
            y_d    = y_nxt;
            idx_d  = idx_q + 10'd1;
            last_d = ((idx_q + 10'd1) == LAST_IDX);
            data_d = pix_nxt;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CANVAS_SNAPSHOT_EN
  // Pure data buffer; only meaningful after a Start, so it needs no reset.
  always_ff @(posedge Clk) begin
    snap_q <= snap_d;
  end
`endif

  assign Pixel_data  = data_q;
  assign Pixel_index = idx_q;
  assign Pixel_valid = valid_q;
  assign Pixel_last  = last_q;
  assign Busy        = busy_q;
  assign Done        = done_q;

endmodule
